mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_pkg.sv | 12 +
 rtl/rr_pick2.sv | 21 ++
 rtl/mem_arbiter.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the two-port RAM arbiter used alongside the hart.
package mem_arbiter_pkg;

    localparam int unsigned N_REQ = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOCK0 = 2'd1,
        LOCK1 = 2'd2
    } arb_state_t;

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin picker: on a tie, the requester not granted last wins.
module rr_pick2
    import mem_arbiter_pkg::*;
(
    input  logic [N_REQ-1:0] i_req,
    input  logic             i_last,
    output logic [N_REQ-1:0] o_gnt
);

    // One-hot pick from the request vector and the last-granted index
    always_comb begin
        o_gnt = '0;
        case (i_req)
            2'b01:   o_gnt = 2'b01;
            2'b10:   o_gnt = 2'b10;
            2'b11:   o_gnt = i_last ? 2'b01 : 2'b10;
            default: o_gnt = 2'b00;
        endcase
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter sharing one single-port synchronous RAM between the hart data port
// (requester 0) and the loader/debug port (requester 1), with bus locking.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic                i_clk,
    input  logic                i_rst,

    input  logic                i_r0_req,
    input  logic                i_r0_lock,
    input  logic [ADDR_W-1:0]   i_r0_addr,
    input  logic                i_r0_wen,
    input  logic [DATA_W-1:0]   i_r0_wdata,
    input  logic [DATA_W/8-1:0] i_r0_mask,
    output logic                o_r0_gnt,
    output logic                o_r0_ack,
    output logic [DATA_W-1:0]   o_r0_rdata,

    input  logic                i_r1_req,
    input  logic                i_r1_lock,
    input  logic [ADDR_W-1:0]   i_r1_addr,
    input  logic                i_r1_wen,
    input  logic [DATA_W-1:0]   i_r1_wdata,
    input  logic [DATA_W/8-1:0] i_r1_mask,
    output logic                o_r1_gnt,
    output logic                o_r1_ack,
    output logic [DATA_W-1:0]   o_r1_rdata,

    output logic                o_mem_en,
    output logic                o_mem_wen,
    output logic [ADDR_W-1:0]   o_mem_addr,
    output logic [DATA_W-1:0]   o_mem_wdata,
    output logic [DATA_W/8-1:0] o_mem_mask,
    input  logic [DATA_W-1:0]   i_mem_rdata
);

    arb_state_t       r_state;
    arb_state_t       w_state_nxt;
    logic             r_last;
    logic             r_ack0;
    logic             r_ack1;
    logic             r_rd0;
    logic             r_rd1;
    logic [N_REQ-1:0] w_req;
    logic [N_REQ-1:0] w_pick;
    logic [N_REQ-1:0] w_gnt;

    assign w_req = {i_r1_req, i_r0_req};

    rr_pick2 u_pick (
        .i_req  (w_req),
        .i_last (r_last),
        .o_gnt  (w_pick)
    );

    // FSM state register
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state: a locked grant enters/keeps LOCKn; dropping lock releases
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_gnt[0] && i_r0_lock) begin
                    w_state_nxt = LOCK0;
                end else if (w_gnt[1] && i_r1_lock) begin
                    w_state_nxt = LOCK1;
                end
            end
            LOCK0:   if (!i_r0_lock) w_state_nxt = IDLE;
            LOCK1:   if (!i_r1_lock) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Grant outputs: picker in IDLE, owner only while locked, none in reset
    always_comb begin
        w_gnt = '0;
        if (!i_rst) begin
            case (r_state)
                IDLE:    w_gnt = w_pick;
                LOCK0:   w_gnt = {1'b0, i_r0_req};
                LOCK1:   w_gnt = {i_r1_req, 1'b0};
                default: w_gnt = '0;
            endcase
        end
    end

    assign o_r0_gnt = w_gnt[0];
    assign o_r1_gnt = w_gnt[1];

    // Round-robin pointer tracks the most recent grant; reset favours r0
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_last <= 1'b1;
        end else if (w_gnt[0]) begin
            r_last <= 1'b0;
        end else if (w_gnt[1]) begin
            r_last <= 1'b1;
        end
    end

    // Pending-ack pipeline: one ack per accepted access, one cycle later
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_ack0 <= 1'b0;
            r_ack1 <= 1'b0;
            r_rd0  <= 1'b0;
            r_rd1  <= 1'b0;
        end else begin
            r_ack0 <= w_gnt[0];
            r_ack1 <= w_gnt[1];
            r_rd0  <= w_gnt[0] & ~i_r0_wen;
            r_rd1  <= w_gnt[1] & ~i_r1_wen;
        end
    end

    assign o_r0_ack   = r_ack0;
    assign o_r1_ack   = r_ack1;
    assign o_r0_rdata = (r_ack0 && r_rd0) ? i_mem_rdata : '0;
    assign o_r1_rdata = (r_ack1 && r_rd1) ? i_mem_rdata : '0;

    // RAM port mux: route the granted requester, quiet bus otherwise
    always_comb begin
        o_mem_en    = |w_gnt;
        o_mem_wen   = 1'b0;
        o_mem_addr  = '0;
        o_mem_wdata = '0;
        o_mem_mask  = '0;
        if (w_gnt[0]) begin
            o_mem_wen   = i_r0_wen;
            o_mem_addr  = i_r0_addr;
            o_mem_wdata = i_r0_wdata;
            o_mem_mask  = i_r0_mask;
        end else if (w_gnt[1]) begin
            o_mem_wen   = i_r1_wen;
            o_mem_addr  = i_r1_addr;
            o_mem_wdata = i_r1_wdata;
            o_mem_mask  = i_r1_mask;
        end
    end

endmodule
